// File: rtl/lcd_spi_rx_if.sv
// Output handshake of the LCD link receiver.
//   rx_valid   : holding register contains a byte (receiver -> consumer)
//   rx_ready   : consumer accepts the byte when rx_valid && rx_ready
//   rx_data    : received byte
//   rx_is_data : rs value captured with rx_data (0 = index, 1 = data)
// Modports: master = receiver side, slave = consumer side.
interface lcd_spi_rx_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  rx_valid;
  logic                  rx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_is_data;

  modport master (
    output rx_valid,
    output rx_data,
    output rx_is_data,
    input  rx_ready
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    input  rx_is_data,
    output rx_ready
  );
endinterface

// File: rtl/lcd_spi_rx.sv
// Panel-side receiver for the serial LCD link (cs/scl/sda/rs, MSB first, sda sampled
// on scl rising edge). The link is oversampled in the clk domain, each byte is
// deserialised, tagged as index (rs=0) or data (rs=1) and offered on a single-entry
// valid/ready holding register. The last index byte and a per-index data-byte count
// are tracked alongside.
//
// Ports:
//   clk, rstn         : receiver clock, asynchronous active-low reset
//   cs_lcd            : chip select, active low (asynchronous to clk)
//   scl_lcd, sda_lcd  : serial clock / data (asynchronous to clk)
//   rs_lcd            : 0 = index byte, 1 = data byte
//   rx_if (master)    : rx_valid / rx_ready / rx_data / rx_is_data
//   rx_index          : last received index byte
//   rx_data_cnt       : data bytes stored since the last index byte (wraps)
//   busy              : receiver is inside a cs-low window
//   frame_err         : one-cycle pulse, cs rose mid-byte
//   overrun           : one-cycle pulse, byte completed while holding register full
//
// Optional feature, enabled by defining LCD_RX_STATS_EN:
//   stat_clr          : synchronous clear of the statistics counters (highest priority)
//   stat_index_cnt    : stored index bytes (saturating)
//   stat_data_cnt     : stored data bytes (saturating)
//   stat_err_cnt      : frame_err + overrun events (saturating)
module lcd_spi_rx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cs_lcd,
  input  logic                  scl_lcd,
  input  logic                  sda_lcd,
  input  logic                  rs_lcd,
  lcd_spi_rx_if.master          rx_if,
  output logic [DATA_WIDTH-1:0] rx_index,
  output logic [CNT_WIDTH-1:0]  rx_data_cnt,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  overrun
`ifdef LCD_RX_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [CNT_WIDTH-1:0]  stat_index_cnt,
  output logic [CNT_WIDTH-1:0]  stat_data_cnt,
  output logic [CNT_WIDTH-1:0]  stat_err_cnt
`endif
);

  localparam int unsigned BitCntW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [0:0] {StIdle, StRecv} state_e;

  // ---------------------------------------------------------------------------
  // Input synchronisers; s3 is edge-detect history for cs and scl only.
  // Reset values are the idle levels of the link.
  // ---------------------------------------------------------------------------
  logic cs_s1_q, cs_s2_q, cs_s3_q;
  logic scl_s1_q, scl_s2_q, scl_s3_q;
  logic sda_s1_q, sda_s2_q;
  logic rs_s1_q, rs_s2_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cs_s1_q  <= 1'b1;
      cs_s2_q  <= 1'b1;
      cs_s3_q  <= 1'b1;
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_s3_q <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      rs_s1_q  <= 1'b0;
      rs_s2_q  <= 1'b0;
    end else begin
      cs_s1_q  <= cs_lcd;
      cs_s2_q  <= cs_s1_q;
      cs_s3_q  <= cs_s2_q;
      scl_s1_q <= scl_lcd;
      scl_s2_q <= scl_s1_q;
      scl_s3_q <= scl_s2_q;
      sda_s1_q <= sda_lcd;
      sda_s2_q <= sda_s1_q;
      rs_s1_q  <= rs_lcd;
      rs_s2_q  <= rs_s1_q;
    end
  end

  logic scl_rise, cs_fall, cs_rise;
  assign scl_rise = scl_s2_q & ~scl_s3_q;
  assign cs_fall  = ~cs_s2_q & cs_s3_q;
  assign cs_rise  = cs_s2_q & ~cs_s3_q;

  // ---------------------------------------------------------------------------
  // Deserialiser FSM
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tag_q, tag_d;
  logic                  byte_done_q, byte_done_d;
  logic                  frame_err_q, frame_err_d;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tag_d       = tag_q;
    byte_done_d = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d   = StRecv;
          bit_cnt_d = '0;
        end
      end
      StRecv: begin
        // scl edge is handled before a coincident cs_rise.
        if (scl_rise) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], sda_s2_q};
          if (bit_cnt_q == BitCntW'(DATA_WIDTH - 1)) begin
            bit_cnt_d   = '0;
            byte_done_d = 1'b1;
            tag_d       = rs_s2_q;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        if (cs_rise) begin
          state_d     = StIdle;
          frame_err_d = (bit_cnt_d != '0);
          bit_cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tag_q       <= 1'b0;
      byte_done_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tag_q       <= tag_d;
      byte_done_q <= byte_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Holding register. The completed byte sits in shift_q/tag_q for the cycle
  // byte_done_q is high; the next scl rise is at least 4 clk away, so it is stable.
  // ---------------------------------------------------------------------------
  logic                  rx_valid_q, rx_valid_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_is_data_q, rx_is_data_d;
  logic [DATA_WIDTH-1:0] rx_index_q, rx_index_d;
  logic [CNT_WIDTH-1:0]  rx_data_cnt_q, rx_data_cnt_d;
  logic                  overrun_q, overrun_d;
  logic                  store;

  // Free slot, or the held byte leaves in this same cycle.
  assign store = byte_done_q & (~rx_valid_q | rx_if.rx_ready);

  always_comb begin
    rx_valid_d    = rx_valid_q;
    rx_data_d     = rx_data_q;
    rx_is_data_d  = rx_is_data_q;
    rx_index_d    = rx_index_q;
    rx_data_cnt_d = rx_data_cnt_q;
    overrun_d     = 1'b0;

    if (rx_valid_q && rx_if.rx_ready) begin
      rx_valid_d = 1'b0;
    end

    if (store) begin
      rx_valid_d   = 1'b1;
      rx_data_d    = shift_q;
      rx_is_data_d = tag_q;
    end else if (byte_done_q) begin
      overrun_d = 1'b1;
    end

    if (byte_done_q) begin
      if (!tag_q) begin
        // Index bytes restart the data count even when dropped.
        rx_index_d    = shift_q;
        rx_data_cnt_d = '0;
      end else if (store) begin
        rx_data_cnt_d = rx_data_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_valid_q    <= 1'b0;
      rx_data_q     <= '0;
      rx_is_data_q  <= 1'b0;
      rx_index_q    <= '0;
      rx_data_cnt_q <= '0;
      overrun_q     <= 1'b0;
    end else begin
      rx_valid_q    <= rx_valid_d;
      rx_data_q     <= rx_data_d;
      rx_is_data_q  <= rx_is_data_d;
      rx_index_q    <= rx_index_d;
      rx_data_cnt_q <= rx_data_cnt_d;
      overrun_q     <= overrun_d;
    end
  end

  assign rx_if.rx_valid   = rx_valid_q;
  assign rx_if.rx_data    = rx_data_q;
  assign rx_if.rx_is_data = rx_is_data_q;
  assign rx_index         = rx_index_q;
  assign rx_data_cnt      = rx_data_cnt_q;
  assign busy             = (state_q == StRecv);
  assign frame_err        = frame_err_q;
  assign overrun          = overrun_q;

`ifdef LCD_RX_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating statistics counters
  // ---------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] stat_index_q, stat_data_q, stat_err_q;
  logic [1:0]           err_inc;

  // frame_err and overrun can pulse in the same cycle.
  assign err_inc = {1'b0, frame_err_q} + {1'b0, overrun_q};

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [1:0]           inc);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, a} + {{(CNT_WIDTH - 1){1'b0}}, inc};
    return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_index_q <= '0;
      stat_data_q  <= '0;
      stat_err_q   <= '0;
    end else if (stat_clr) begin
      stat_index_q <= '0;
      stat_data_q  <= '0;
      stat_err_q   <= '0;
    end else begin
      stat_index_q <= sat_add(stat_index_q, {1'b0, store & ~tag_q});
      stat_data_q  <= sat_add(stat_data_q, {1'b0, store & tag_q});
      stat_err_q   <= sat_add(stat_err_q, err_inc);
    end
  end

  assign stat_index_cnt = stat_index_q;
  assign stat_data_cnt  = stat_data_q;
  assign stat_err_cnt   = stat_err_q;
`endif

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Directed bench for lcd_spi_rx: drives framed serial bytes (scl 4 clk per phase),
// records handshake transfers and error pulses on the falling clk edge, and checks
// outputs against hand-computed values.
module tb_lcd_spi_rx;

  logic clk = 1'b0;
  logic rstn;
  logic cs, scl, sda, rs;
  logic [7:0]  rx_index;
  logic [15:0] rx_data_cnt;
  logic busy, frame_err, overrun;
`ifdef LCD_RX_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_index_cnt, stat_data_cnt, stat_err_cnt;
`endif

  lcd_spi_rx_if #(.DATA_WIDTH(8)) rx_if ();

  lcd_spi_rx #(
    .DATA_WIDTH(8),
    .CNT_WIDTH (16)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .cs_lcd        (cs),
    .scl_lcd       (scl),
    .sda_lcd       (sda),
    .rs_lcd        (rs),
    .rx_if         (rx_if),
    .rx_index      (rx_index),
    .rx_data_cnt   (rx_data_cnt),
    .busy          (busy),
    .frame_err     (frame_err),
    .overrun       (overrun)
`ifdef LCD_RX_STATS_EN
    ,
    .stat_clr      (stat_clr),
    .stat_index_cnt(stat_index_cnt),
    .stat_data_cnt (stat_data_cnt),
    .stat_err_cnt  (stat_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int busy_cnt = 0;
  logic [8:0] xfer_q[$];

  // Transfers and pulses sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rx_if.rx_valid && rx_if.rx_ready) xfer_q.push_back({rx_if.rx_is_data, rx_if.rx_data});
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (busy) busy_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic scl_bit(input logic b);
    scl = 1'b0;
    sda = b;
    tick(4);
    scl = 1'b1;
    tick(4);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic r);
    rs = r;
    for (int i = 7; i >= 0; i--) scl_bit(b[i]);
  endtask

  task automatic frame(input logic [7:0] b, input logic r);
    cs = 1'b0;
    tick(4);
    send_byte(b, r);
    tick(4);
    cs = 1'b1;
    tick(8);
  endtask

  task automatic consume();
    rx_if.rx_ready = 1'b1;
    tick(1);
    rx_if.rx_ready = 1'b0;
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_valid"}, 32'(rx_if.rx_valid), 0);
    check({pfx, "_data"}, 32'(rx_if.rx_data), 0);
    check({pfx, "_is_data"}, 32'(rx_if.rx_is_data), 0);
    check({pfx, "_index"}, 32'(rx_index), 0);
    check({pfx, "_cnt"}, 32'(rx_data_cnt), 0);
    check({pfx, "_busy"}, 32'(busy), 0);
    check({pfx, "_frame_err"}, 32'(frame_err), 0);
    check({pfx, "_overrun"}, 32'(overrun), 0);
  endtask

  int busy_snap;

  initial begin
    rstn = 1'b0;
    cs = 1'b1; scl = 1'b1; sda = 1'b1; rs = 1'b0;
    rx_if.rx_ready = 1'b0;
`ifdef LCD_RX_STATS_EN
    stat_clr = 1'b0;
`endif
    tick(3);
    check_reset("reset");
    rstn = 1'b1;
    tick(3);

    // Index 0x2C
    cs = 1'b0;
    tick(4);
    check("busy_in_frame", 32'(busy), 1);
    send_byte(8'h2C, 1'b0);
    tick(4);
    cs = 1'b1;
    tick(8);
    check("idx_valid", 32'(rx_if.rx_valid), 1);
    check("idx_data", 32'(rx_if.rx_data), 32'h2C);
    check("idx_is_data", 32'(rx_if.rx_is_data), 0);
    check("idx_index", 32'(rx_index), 32'h2C);
    check("idx_cnt", 32'(rx_data_cnt), 0);
    check("idx_no_err", 32'(ferr_cnt + ovr_cnt), 0);
    check("idx_busy_after", 32'(busy), 0);
    consume();
    check("idx_consumed", 32'(rx_if.rx_valid), 0);
    check("idx_xfer_n", 32'(xfer_q.size()), 1);
    check("idx_xfer", 32'(xfer_q[0]), 32'h02C);

    // Three data frames, consumer always ready
    rx_if.rx_ready = 1'b1;
    frame(8'hA5, 1'b1);
    frame(8'h5A, 1'b1);
    frame(8'hFF, 1'b1);
    rx_if.rx_ready = 1'b0;
    check("data_xfer_n", 32'(xfer_q.size()), 4);
    check("data_xfer0", 32'(xfer_q[1]), 32'h1A5);
    check("data_xfer1", 32'(xfer_q[2]), 32'h15A);
    check("data_xfer2", 32'(xfer_q[3]), 32'h1FF);
    check("data_cnt", 32'(rx_data_cnt), 3);
    check("data_valid", 32'(rx_if.rx_valid), 0);
    check("data_index", 32'(rx_index), 32'h2C);

    // Two bytes in one window, consumer stalled -> overrun on the second
    cs = 1'b0;
    tick(4);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    tick(4);
    cs = 1'b1;
    tick(8);
    check("ovr_pulses", 32'(ovr_cnt), 1);
    check("ovr_valid", 32'(rx_if.rx_valid), 1);
    check("ovr_data", 32'(rx_if.rx_data), 32'h11);
    check("ovr_is_data", 32'(rx_if.rx_is_data), 1);
    check("ovr_cnt", 32'(rx_data_cnt), 4);
    consume();
    check("ovr_consumed", 32'(rx_if.rx_valid), 0);
    check("ovr_xfer_n", 32'(xfer_q.size()), 5);
    check("ovr_xfer", 32'(xfer_q[4]), 32'h111);

    // cs rises after 5 bits
    cs = 1'b0;
    tick(4);
    scl_bit(1'b1); scl_bit(1'b0); scl_bit(1'b1); scl_bit(1'b0); scl_bit(1'b1);
    cs = 1'b1;
    tick(8);
    check("ferr_pulses", 32'(ferr_cnt), 1);
    check("ferr_valid", 32'(rx_if.rx_valid), 0);
    check("ferr_busy", 32'(busy), 0);
    frame(8'h3C, 1'b0);
    check("after_ferr_valid", 32'(rx_if.rx_valid), 1);
    check("after_ferr_data", 32'(rx_if.rx_data), 32'h3C);
    check("after_ferr_index", 32'(rx_index), 32'h3C);
    check("after_ferr_cnt", 32'(rx_data_cnt), 0);
    check("after_ferr_pulses", 32'(ferr_cnt), 1);
    consume();
    check("after_ferr_xfer", 32'(xfer_q[5]), 32'h03C);

    // scl toggling with cs high is ignored
    busy_snap = busy_cnt;
    for (int i = 0; i < 8; i++) scl_bit(1'b1);
    tick(8);
    check("cs_high_busy", 32'(busy_cnt - busy_snap), 0);
    check("cs_high_valid", 32'(rx_if.rx_valid), 0);
    check("cs_high_xfer_n", 32'(xfer_q.size()), 6);

    // Reset in the middle of a byte
    cs = 1'b0;
    tick(4);
    scl_bit(1'b1); scl_bit(1'b1); scl_bit(1'b0); scl_bit(1'b0);
    rstn = 1'b0;
    tick(2);
    cs = 1'b1; scl = 1'b1; sda = 1'b1; rs = 1'b0;
    tick(2);
    check_reset("midrst");
    rstn = 1'b1;
    tick(4);
    frame(8'h81, 1'b1);
    check("post_rst_valid", 32'(rx_if.rx_valid), 1);
    check("post_rst_data", 32'(rx_if.rx_data), 32'h81);
    check("post_rst_is_data", 32'(rx_if.rx_is_data), 1);
    check("post_rst_index", 32'(rx_index), 0);
    check("post_rst_cnt", 32'(rx_data_cnt), 1);
    consume();

`ifdef LCD_RX_STATS_EN
    stat_clr = 1'b1;
    tick(1);
    stat_clr = 1'b0;
    rx_if.rx_ready = 1'b1;
    frame(8'h2A, 1'b0);
    frame(8'h01, 1'b1);
    frame(8'h02, 1'b1);
    frame(8'h03, 1'b1);
    frame(8'h04, 1'b1);
    cs = 1'b0;
    tick(4);
    scl_bit(1'b0); scl_bit(1'b1); scl_bit(1'b0);
    cs = 1'b1;
    tick(8);
    rx_if.rx_ready = 1'b0;
    check("stat_index", 32'(stat_index_cnt), 1);
    check("stat_data", 32'(stat_data_cnt), 4);
    check("stat_err", 32'(stat_err_cnt), 1);
    stat_clr = 1'b1;
    tick(1);
    stat_clr = 1'b0;
    check("stat_clr_index", 32'(stat_index_cnt), 0);
    check("stat_clr_data", 32'(stat_data_cnt), 0);
    check("stat_clr_err", 32'(stat_err_cnt), 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
